// File: rtl/tristate_bus_arbiter_pkg.sv
// Shared constants and helpers for the tristate bus arbiter.
// State codes, source count and the one-hot decode.
package tristate_bus_arbiter_pkg;

  localparam int NSRC = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  function automatic logic [NSRC-1:0] onehot(
    input logic [1:0] idx
  );
    logic [NSRC-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Rotating-priority search for the tristate bus arbiter.
// Searches last+1, last+2, ... modulo NSRC.
module rr_pick
  import tristate_bus_arbiter_pkg::*;
(
  input  logic [NSRC-1:0] req,
  input  logic [1:0]      last,
  output logic            valid,
  output logic [1:0]      idx
);

  always_comb begin : p_pick
    logic [1:0] w_c;
    w_c   = last;
    idx   = last;
    valid = |req;
    // Walk from farthest to nearest so the nearest hit wins.
    for (int k = NSRC; k >= 1; k--) begin
      w_c = last + 2'(k);
      if (req[w_c]) begin
        idx = w_c;
      end
    end
  end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a 4-source tristate bus.
// Bounded tenure plus an all-off turnaround between owners.
module tristate_bus_arbiter
  import tristate_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD    = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] req,
  output logic [NSRC-1:0] gnt,
  output logic [1:0]      sel,
  output logic            bus_en,
  output logic            preempt,
  output logic            busy
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);

  logic [1:0]      r_state;
  logic [HW-1:0]   r_hold;
  logic [TW-1:0]   r_turn;
  logic [1:0]      r_last;
  logic [NSRC-1:0] r_gnt;
  logic [1:0]      r_sel;
  logic            r_bus_en;
  logic            r_preempt;
  logic            r_busy;

  logic            w_valid;
  logic [1:0]      w_idx;
  logic            w_own_req;
  logic            w_others;
  logic            w_at_max;
  logic            w_turn_done;

  rr_pick u_pick (
    .req   (req),
    .last  (r_last),
    .valid (w_valid),
    .idx   (w_idx)
  );

  // r_sel holds the owner index throughout GRANT.
  assign w_own_req   = req[r_sel];
  assign w_others    = |(req & ~onehot(r_sel));
  assign w_at_max    = (r_hold == HW'(MAX_HOLD));
  assign w_turn_done = (r_turn == TW'(TURN_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_turn    <= '0;
      r_last    <= 2'd3;
      r_gnt     <= '0;
      r_sel     <= 2'd0;
      r_bus_en  <= 1'b0;
      r_preempt <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_state  <= ST_GRANT;
            r_gnt    <= onehot(w_idx);
            r_sel    <= w_idx;
            r_bus_en <= 1'b1;
            r_hold   <= HW'(1);
            r_busy   <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (!w_own_req || (w_at_max && w_others)) begin
            r_state   <= ST_TURN;
            r_gnt     <= '0;
            r_bus_en  <= 1'b0;
            r_turn    <= TW'(1);
            r_last    <= r_sel;
            r_preempt <= w_own_req;
          end else if (!w_at_max) begin
            r_hold <= r_hold + HW'(1);
          end
        end
        ST_TURN: begin
          if (w_turn_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_turn <= r_turn + TW'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_gnt    <= '0;
          r_bus_en <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign sel     = r_sel;
  assign bus_en  = r_bus_en;
  assign preempt = r_preempt;
  assign busy    = r_busy;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios plus random
// requests checked against a tenure/gap level reference model.
module tb_tristate_bus_arbiter;

  localparam int MH_A = 4;
  localparam int TC_A = 1;
  localparam int MH_B = 8;
  localparam int TC_B = 3;

  logic       clk;
  logic       rst;
  logic [3:0] req;

  logic [3:0] gnt_a, gnt_b;
  logic [1:0] sel_a, sel_b;
  logic       bus_en_a, bus_en_b;
  logic       preempt_a, preempt_b;
  logic       busy_a, busy_b;

  int n_checks;
  int n_fail;
  bit chk_en;

  tristate_bus_arbiter #(.MAX_HOLD(MH_A), .TURN_CYCLES(TC_A)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt_a),
    .sel     (sel_a),
    .bus_en  (bus_en_a),
    .preempt (preempt_a),
    .busy    (busy_a)
  );

  tristate_bus_arbiter #(.MAX_HOLD(MH_B), .TURN_CYCLES(TC_B)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt_b),
    .sel     (sel_b),
    .bus_en  (bus_en_b),
    .preempt (preempt_b),
    .busy    (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: owner (-1 none), tenure length, remaining gap.
  int m_owner  [2];
  int m_tenure [2];
  int m_gap    [2];
  int m_last   [2];
  int m_sel    [2];
  bit m_pre    [2];
  int m_mh     [2];
  int m_tc     [2];
  initial begin
    m_mh[0] = MH_A; m_tc[0] = TC_A;
    m_mh[1] = MH_B; m_tc[1] = TC_B;
  end

  always @(posedge clk or posedge rst) begin
    int c;
    bit found;
    bit others;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k] = -1; m_tenure[k] = 0; m_gap[k] = 0;
        m_last[k] = 3; m_sel[k] = 0; m_pre[k] = 0;
      end else begin
        m_pre[k] = 0;
        if (m_owner[k] >= 0) begin
          others = (req & ~(4'b0001 << m_owner[k])) != 4'b0;
          if (!req[m_owner[k]] ||
              (m_tenure[k] >= m_mh[k] && others)) begin
            m_pre[k]   = req[m_owner[k]];
            m_last[k]  = m_owner[k];
            m_owner[k] = -1;
            m_gap[k]   = m_tc[k];
          end else if (m_tenure[k] < m_mh[k]) begin
            m_tenure[k]++;
          end
        end else if (m_gap[k] > 0) begin
          m_gap[k]--;
        end else if (req != 4'b0) begin
          found = 0;
          for (int d = 1; d <= 4; d++) begin
            c = (m_last[k] + d) % 4;
            if (!found && req[c]) begin
              m_owner[k] = c;
              found = 1;
            end
          end
          m_tenure[k] = 1;
          m_sel[k]    = m_owner[k];
        end
      end
    end
  end

  // Always-on invariants: no multi-hot grant, bus_en tracks gnt.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if ($countones(gnt_a) > 1 || $countones(gnt_b) > 1) begin
        n_fail++;
        $display("FAIL onehot: gnt_a=%b gnt_b=%b need <=1 bit", gnt_a, gnt_b);
      end
      n_checks++;
      if (bus_en_a !== (gnt_a != 0) || bus_en_b !== (gnt_b != 0)) begin
        n_fail++;
        $display("FAIL bus_en_track: en_a=%b gnt_a=%b en_b=%b gnt_b=%b",
                 bus_en_a, gnt_a, bus_en_b, gnt_b);
      end
    end
  end

  task automatic do_reset(input logic [3:0] r);
    @(negedge clk);
    rst = 1'b1;
    req = r;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0101;
    @(negedge clk);
    n_checks++;
    if ({gnt_a, sel_a, bus_en_a, preempt_a, busy_a} !== 9'b0 ||
        {gnt_b, sel_b, bus_en_b, preempt_b, busy_b} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state: a=%b b=%b need all zero",
               {gnt_a, sel_a, bus_en_a, preempt_a, busy_a},
               {gnt_b, sel_b, bus_en_b, preempt_b, busy_b});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 4'b0001 || sel_a !== 2'b00 || bus_en_a !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: gnt=%b sel=%b en=%b need 0001 00 1",
               gnt_a, sel_a, bus_en_a);
    end
    req = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (gnt_a !== 4'b0000) begin
        n_fail++;
        $display("FAIL gap_reset[%0d]: gnt=%b need 0000", i, gnt_a);
      end
    end
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 4'b0100 || sel_a !== 2'b10) begin
      n_fail++;
      $display("FAIL second_grant: gnt=%b sel=%b need 0100 10", gnt_a, sel_a);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    do_reset(4'b1111);
    for (int t = 0; t < 5; t++) begin
      exp = 4'b0001 << (t % 4);
      for (int c = 0; c < MH_A; c++) begin
        @(negedge clk);
        n_checks++;
        if (gnt_a !== exp || preempt_a !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_tenure t%0d c%0d: gnt=%b pre=%b need %b 0",
                   t, c, gnt_a, preempt_a, exp);
        end
      end
      if (t < 4) begin
        @(negedge clk);
        n_checks++;
        if (gnt_a !== 4'b0 || preempt_a !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_preempt t%0d: gnt=%b pre=%b need 0000 1",
                   t, gnt_a, preempt_a);
        end
        @(negedge clk);
        n_checks++;
        if (gnt_a !== 4'b0 || preempt_a !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_gap t%0d: gnt=%b pre=%b need 0000 0",
                   t, gnt_a, preempt_a);
        end
      end
    end
  endtask

  task automatic test_sole;
    do_reset(4'b0010);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (gnt_a !== 4'b0010 || preempt_a !== 1'b0 ||
          gnt_b !== 4'b0010 || preempt_b !== 1'b0) begin
        n_fail++;
        $display("FAIL sole[%0d]: a=%b/%b b=%b/%b need 0010/0",
                 i, gnt_a, preempt_a, gnt_b, preempt_b);
      end
    end
  endtask

  task automatic test_async_reset;
    do_reset(4'b0010);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (gnt_a !== 4'b0 || bus_en_a !== 1'b0 || busy_a !== 1'b0 ||
        gnt_b !== 4'b0 || bus_en_b !== 1'b0 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: a=%b%b%b b=%b%b%b need zero",
               gnt_a, bus_en_a, busy_a, gnt_b, bus_en_b, busy_b);
    end
    @(negedge clk);
    req = 4'b1000;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gnt_a !== 4'b1000 || sel_a !== 2'b11 || bus_en_a !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_grant: gnt=%b sel=%b en=%b need 1000 11 1",
               gnt_a, sel_a, bus_en_a);
    end
  endtask

  task automatic test_turn3;
    do_reset(4'b0100);
    @(negedge clk);
    n_checks++;
    if (gnt_b !== 4'b0100) begin
      n_fail++;
      $display("FAIL turn3_owner: gnt=%b need 0100", gnt_b);
    end
    req = 4'b1000;
    for (int i = 0; i < TC_B + 1; i++) begin
      @(negedge clk);
      n_checks++;
      if (gnt_b !== 4'b0 || sel_b !== 2'b10) begin
        n_fail++;
        $display("FAIL turn3_gap[%0d]: gnt=%b sel=%b need 0000 10",
                 i, gnt_b, sel_b);
      end
    end
    @(negedge clk);
    n_checks++;
    if (gnt_b !== 4'b1000 || sel_b !== 2'b11) begin
      n_fail++;
      $display("FAIL turn3_next: gnt=%b sel=%b need 1000 11", gnt_b, sel_b);
    end
  endtask

  task automatic test_random;
    logic [3:0] eg;
    logic [1:0] es;
    logic [3:0] flip;
    int shown;
    shown = 0;
    do_reset(4'($urandom_range(0, 15)));
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      eg = (m_owner[0] >= 0) ? (4'b0001 << m_owner[0]) : 4'b0;
      es = 2'(m_sel[0]);
      n_checks++;
      if (gnt_a !== eg || sel_a !== es || preempt_a !== m_pre[0] ||
          busy_a !== (m_owner[0] >= 0 || m_gap[0] > 0)) begin
        n_fail++;
        if (shown++ < 10)
          $display("FAIL rand_a cyc%0d: gnt=%b sel=%b pre=%b busy=%b need %b %b %b",
                   i, gnt_a, sel_a, preempt_a, busy_a, eg, es, m_pre[0]);
      end
      eg = (m_owner[1] >= 0) ? (4'b0001 << m_owner[1]) : 4'b0;
      es = 2'(m_sel[1]);
      n_checks++;
      if (gnt_b !== eg || sel_b !== es || preempt_b !== m_pre[1] ||
          busy_b !== (m_owner[1] >= 0 || m_gap[1] > 0)) begin
        n_fail++;
        if (shown++ < 10)
          $display("FAIL rand_b cyc%0d: gnt=%b sel=%b pre=%b busy=%b need %b %b %b",
                   i, gnt_b, sel_b, preempt_b, busy_b, eg, es, m_pre[1]);
      end
      flip = '0;
      for (int b = 0; b < 4; b++)
        flip[b] = ($urandom_range(0, 9) == 0);
      req = req ^ flip;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    chk_en   = 1'b0;
    rst      = 1'b1;
    req      = 4'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    test_reset;
    test_round_robin;
    test_sole;
    test_async_reset;
    test_turn3;
    test_random;
    chk_en = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
